alif_param_loader: RTL

Serial configuration controller for the single-channel dual-leak ALIF neuron. It takes the load_mode/serial_data pin pair, deserialises a checksummed parameter frame, and atomically commits the parameters to the neuron datapath. It drives params_ready and holds the neuron while a load is in progress. It sits between the top-level pin wrapper and the neuron core, replacing ad-hoc shift logic inside the system module.

---
 rtl/alif_cfg_pkg.sv | 25 ++
 rtl/alif_param_loader_if.sv | 23 ++
 rtl/alif_sync_ff.sv | 23 ++
 rtl/alif_param_loader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alif_cfg_pkg.sv
// Shared configuration for the ALIF parameter loader: frame geometry, parameter word
// indices, reset defaults and the loader FSM state type.
package alif_cfg_pkg;

   localparam int unsigned N_PARAMS_DEFAULT = 4;

   localparam int unsigned P_THRESH    = 0;
   localparam int unsigned P_LEAK_FAST = 1;
   localparam int unsigned P_LEAK_SLOW = 2;
   localparam int unsigned P_ADAPT     = 3;

   localparam logic [31:0] DEFAULT_PARAMS = 32'h0804_0130;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } state_t;

   // Payload bytes plus one trailing XOR checksum byte
   function automatic int unsigned frame_bits(input int unsigned n_params);
      return 8 * (n_params + 1);
   endfunction

endpackage

// File: rtl/alif_param_loader_if.sv
// Pin-side and neuron-side signals of the parameter loader, bundled for port connection.
interface alif_param_loader_if #(
   parameter int unsigned N_PARAMS = alif_cfg_pkg::N_PARAMS_DEFAULT
);

   logic                  load_mode;
   logic                  serial_data;
   logic [8*N_PARAMS-1:0] params_out;
   logic                  params_ready;
   logic                  load_error;
   logic                  neuron_hold;

   modport master (
      output load_mode, serial_data,
      input  params_out, params_ready, load_error, neuron_hold
   );

   modport slave (
      input  load_mode, serial_data,
      output params_out, params_ready, load_error, neuron_hold
   );

endinterface

// File: rtl/alif_sync_ff.sv
// N-stage flop synchroniser for an asynchronous single-bit pin.
module alif_sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] pipe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe <= '0;
      end else begin
         pipe <= STAGES'({pipe, d});
      end
   end

   assign q = pipe[STAGES-1];

endmodule

// File: rtl/alif_param_loader.sv
// Deserialises a checksummed parameter frame from the load_mode/serial_data pins and
// commits it atomically to the neuron core, holding the neuron while a load is in flight.
module alif_param_loader
   import alif_cfg_pkg::*;
#(
   parameter int unsigned           N_PARAMS       = N_PARAMS_DEFAULT,
   parameter logic [8*N_PARAMS-1:0] DEFAULT_PARAMS = (8*N_PARAMS)'(alif_cfg_pkg::DEFAULT_PARAMS),
   parameter int unsigned           SYNC_STAGES    = 2
) (
   input logic                clk,
   input logic                rst_n,
   alif_param_loader_if.slave bus
);

   localparam int unsigned FRAME_BITS = frame_bits(N_PARAMS);
   localparam int unsigned PW         = 8 * N_PARAMS;
   localparam int unsigned CW         = $clog2(FRAME_BITS + 2);

   logic lm_s;
   logic sd_s;
   logic lm_q;

   state_t               state,   state_nx;
   logic [FRAME_BITS-1:0] sr,      sr_nx;
   logic [CW-1:0]        bit_cnt, cnt_nx;
   logic [7:0]           xor_acc, xor_nx;
   logic [PW-1:0]        params,  params_nx;
   logic                 ready,   ready_nx;
   logic                 err,     err_nx;
   logic                 hold,    hold_nx;

   logic [PW-1:0]        frame_words;
   logic                 frame_ok;

   alif_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lm (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.load_mode),
      .q     (lm_s)
   );

   alif_sync_ff #(.STAGES(SYNC_STAGES)) u_sync_sd (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.serial_data),
      .q     (sd_s)
   );

   // First-received byte sits at the top of the shift register and maps to word 0
   always_comb begin
      frame_words = '0;
      for (int i = 0; i < int'(N_PARAMS); i++) begin
         frame_words[8*i +: 8] = sr[FRAME_BITS-1-8*i -: 8];
      end
   end

   assign frame_ok = (bit_cnt == CW'(FRAME_BITS)) && (xor_acc == 8'h00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         lm_q    <= 1'b0;
         sr      <= '0;
         bit_cnt <= '0;
         xor_acc <= '0;
         params  <= DEFAULT_PARAMS;
         ready   <= 1'b0;
         err     <= 1'b0;
         hold    <= 1'b0;
      end else begin
         state   <= state_nx;
         lm_q    <= lm_s;
         sr      <= sr_nx;
         bit_cnt <= cnt_nx;
         xor_acc <= xor_nx;
         params  <= params_nx;
         ready   <= ready_nx;
         err     <= err_nx;
         hold    <= hold_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      sr_nx     = sr;
      cnt_nx    = bit_cnt;
      xor_nx    = xor_acc;
      params_nx = params;
      ready_nx  = ready;
      err_nx    = err;
      hold_nx   = hold;

      case (state)
         IDLE: begin
            if (lm_s && !lm_q) begin
               sr_nx    = FRAME_BITS'(sd_s);
               cnt_nx   = CW'(1);
               xor_nx   = 8'h00;
               state_nx = SHIFT;
               hold_nx  = 1'b1;
               ready_nx = 1'b0;
               err_nx   = 1'b0;
            end
         end

         SHIFT: begin
            if (!lm_s) begin
               state_nx = CHECK;
            end else if (bit_cnt < CW'(FRAME_BITS)) begin
               sr_nx  = {sr[FRAME_BITS-2:0], sd_s};
               cnt_nx = bit_cnt + CW'(1);
               // Fold each byte into the checksum as its last bit arrives
               if (bit_cnt[2:0] == 3'd7) begin
                  xor_nx = xor_acc ^ {sr[6:0], sd_s};
               end
            end else if (bit_cnt == CW'(FRAME_BITS)) begin
               cnt_nx = CW'(FRAME_BITS + 1);
            end
         end

         CHECK: begin
            state_nx = IDLE;
            hold_nx  = 1'b0;
            if (frame_ok) begin
               params_nx = frame_words;
               ready_nx  = 1'b1;
               err_nx    = 1'b0;
            end else begin
               ready_nx  = 1'b0;
               err_nx    = 1'b1;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign bus.params_out   = params;
   assign bus.params_ready = ready;
   assign bus.load_error   = err;
   assign bus.neuron_hold  = hold;

endmodule
